// File: rtl/axis_downsizer_ext_if.sv
// AXI4-Stream bundle (data, last, valid, ready) shared by the wide input side
// and the narrow output side of the downsizer.
interface axis_downsizer_ext_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_downsizer_ext.sv
// Splits each wide AXI4-Stream beat into N = min(cfg_words, RATIO-1) + 1 narrow
// words, LSB- or MSB-first, with tlast on the final word and a 2-entry skid output.
module axis_downsizer_ext #(
  parameter int  S_AXIS_TDATA_WIDTH = 128,
  parameter int  M_AXIS_TDATA_WIDTH = 32,
  localparam int RATIO              = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH,
  localparam int CNTR_WIDTH         = $clog2(RATIO)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_words,
  input  logic                  cfg_order,
  output logic                  sts_busy,
  axis_downsizer_ext_if.slave   s_axis,
  axis_downsizer_ext_if.master  m_axis
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [CNTR_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]         nlast_q, nlast_d;
  logic                          order_q, order_d;
  logic                          tlast_q, tlast_d;
  logic [S_AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                          rdy_en_q;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic [M_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                          sk_valid_q, sk_valid_d;
  logic                          sk_last_q, sk_last_d;
  logic [M_AXIS_TDATA_WIDTH-1:0] sk_data_q, sk_data_d;

  logic                          stage_rdy_s;
  logic                          accept_s;
  logic [CNTR_WIDTH-1:0]         cfg_last_s;
  logic                          push_s;
  logic                          push_last_s;
  logic [M_AXIS_TDATA_WIDTH-1:0] push_data_s;

  function automatic logic [M_AXIS_TDATA_WIDTH-1:0] pick_word(
    input logic [S_AXIS_TDATA_WIDTH-1:0] beat,
    input logic [CNTR_WIDTH-1:0]         idx
  );
    pick_word = beat[int'(idx)*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
  endfunction

  // The skid register being empty is the only thing the upstream waits on, so
  // s_axis_tready never sees m_axis_tready combinationally.
  assign stage_rdy_s   = rdy_en_q & ~sk_valid_q;
  assign s_axis.tready = stage_rdy_s & (state_q == IDLE);
  assign accept_s      = s_axis.tvalid & s_axis.tready;

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tlast  = out_last_q;
  assign sts_busy      = (state_q == EMIT);

  // Word sequencer: word 0 leaves on the acceptance cycle, the rest from the holding register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nlast_d     = nlast_q;
    order_d     = order_q;
    tlast_d     = tlast_q;
    data_d      = data_q;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    push_data_s = '0;
    if (int'(cfg_words) > RATIO - 1) begin
      cfg_last_s = CNTR_WIDTH'(RATIO - 1);
    end else begin
      cfg_last_s = cfg_words;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          data_d      = s_axis.tdata;
          tlast_d     = s_axis.tlast;
          order_d     = cfg_order;
          nlast_d     = cfg_last_s;
          push_s      = 1'b1;
          push_data_s = pick_word(s_axis.tdata, cfg_order ? cfg_last_s : '0);
          push_last_s = s_axis.tlast & (cfg_last_s == '0);
          if (cfg_last_s != '0) begin
            state_d = EMIT;
            cnt_d   = CNTR_WIDTH'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (stage_rdy_s) begin
          push_s      = 1'b1;
          push_data_s = pick_word(data_q, order_q ? (nlast_q - cnt_q) : cnt_q);
          push_last_s = tlast_q & (cnt_q == nlast_q);
          if (cnt_q == nlast_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTR_WIDTH'(1);
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register plus one skid entry; a push only happens while the skid is empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    sk_valid_d  = sk_valid_q;
    sk_last_d   = sk_last_q;
    sk_data_d   = sk_data_q;
    if (!out_valid_q || m_axis.tready) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_last_d  = sk_last_q;
        out_data_d  = sk_data_q;
        sk_valid_d  = 1'b0;
      end else if (push_s) begin
        out_valid_d = 1'b1;
        out_last_d  = push_last_s;
        out_data_d  = push_data_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (push_s) begin
        sk_valid_d = 1'b1;
        sk_last_d  = push_last_s;
        sk_data_d  = push_data_s;
      end else begin
        sk_valid_d = sk_valid_q;
      end
    end
  end

  // State registers; rdy_en_q keeps s_axis_tready low until one cycle after reset release.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nlast_q     <= '0;
      order_q     <= 1'b0;
      tlast_q     <= 1'b0;
      data_q      <= '0;
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      sk_valid_q  <= 1'b0;
      sk_last_q   <= 1'b0;
      sk_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nlast_q     <= nlast_d;
      order_q     <= order_d;
      tlast_q     <= tlast_d;
      data_q      <= data_d;
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      sk_valid_q  <= sk_valid_d;
      sk_last_q   <= sk_last_d;
      sk_data_q   <= sk_data_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer_ext.sv
// Directed bench for axis_downsizer_ext: word order, truncation, tlast placement,
// back-to-back timing, reset mid-beat and a random-backpressure scoreboard run.
module tb_axis_downsizer_ext;

  logic       aclk;
  logic       aresetn;
  logic [1:0] cfg_words;
  logic       cfg_order;
  logic       sts_busy;

  axis_downsizer_ext_if #(.W(128)) s_if ();
  axis_downsizer_ext_if #(.W(32))  m_if ();

  axis_downsizer_ext #(
    .S_AXIS_TDATA_WIDTH (128),
    .M_AXIS_TDATA_WIDTH (32)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cfg_words (cfg_words),
    .cfg_order (cfg_order),
    .sts_busy  (sts_busy),
    .s_axis    (s_if),
    .m_axis    (m_if)
  );

  localparam logic [127:0] BEAT_A = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] BEAT_B = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [32:0] exp_q[$];
  int          acc_cyc[$];
  int          out_cyc[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;
  logic        rnd_done   = 1'b0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: word k of N comes from index k (LSB-first) or N-1-k (MSB-first).
  task automatic model_beat(input logic [127:0] d, input logic l, input logic [1:0] w, input logic o);
    int n;
    int idx;
    n = int'(w) + 1;
    for (int k = 0; k < n; k++) begin
      idx = o ? (n - 1 - k) : k;
      exp_q.push_back({(k == n - 1) ? l : 1'b0, d[idx*32 +: 32]});
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input logic l, input logic [1:0] w, input logic o);
    logic acc;
    acc          = 1'b0;
    s_if.tdata   = d;
    s_if.tlast   = l;
    cfg_words    = w;
    cfg_order    = o;
    s_if.tvalid  = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge aclk);
      acc = (s_if.tready === 1'b1);
      @(posedge aclk);
      #1;
    end
    chk("accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
      @(posedge aclk);
      #1;
    end
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: scoreboard, hold-stability under backpressure, handshake timestamps.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge aclk);
      if (s_if.tvalid === 1'b1 && s_if.tready === 1'b1) acc_cyc.push_back(cyc);
      if (prev_stall)
        chk("hold_stable", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, prev_word}));
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'({m_if.tlast, m_if.tdata}), 64'h1_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word", 64'({m_if.tlast, m_if.tdata}), 64'(e));
        end
      end
      prev_stall = (aresetn === 1'b1) && (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
      prev_word  = {m_if.tlast, m_if.tdata};
    end
  end

  initial begin
    aresetn     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    cfg_words   = 2'd3;
    cfg_order   = 1'b0;
    m_if.tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_m_tdata",  64'(m_if.tdata),  64'd0);
    chk("rst_m_tlast",  64'(m_if.tlast),  64'd0);
    chk("rst_busy",     64'(sts_busy),    64'd0);
    chk("rst_s_tready", 64'(s_if.tready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_rst", 64'(s_if.tready), 64'd1);
    m_if.tready = 1'b1;

    // Four words LSB-first; cfg changed mid-beat must not matter.
    acc_cyc.delete();
    out_cyc.delete();
    exp_q.push_back({1'b0, 32'h1111_1111});
    exp_q.push_back({1'b0, 32'h2222_2222});
    exp_q.push_back({1'b0, 32'h3333_3333});
    exp_q.push_back({1'b1, 32'h4444_4444});
    send_beat(BEAT_A, 1'b1, 2'd3, 1'b0);
    chk("t1_busy", 64'(sts_busy), 64'd1);
    cfg_words   = 2'd0;
    cfg_order   = 1'b1;
    s_if.tvalid = 1'b0;
    drain();
    chk("t1_idle", 64'(sts_busy), 64'd0);
    chk("t1_count", 64'(out_cyc.size()), 64'd4);
    if (out_cyc.size() == 4 && acc_cyc.size() == 1) begin
      chk("t1_latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd1);
      chk("t1_span",    64'(out_cyc[3] - out_cyc[0]), 64'd3);
    end

    // Two words MSB-first; upper words dropped.
    out_cyc.delete();
    exp_q.push_back({1'b0, 32'h2222_2222});
    exp_q.push_back({1'b1, 32'h1111_1111});
    send_beat(BEAT_A, 1'b1, 2'd1, 1'b1);
    s_if.tvalid = 1'b0;
    drain();
    chk("t2_count", 64'(out_cyc.size()), 64'd2);

    // Eight back-to-back four-word beats.
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      logic [127:0] d;
      d = {32'hA000_0000 + 32'(4*i+3), 32'hA000_0000 + 32'(4*i+2),
           32'hA000_0000 + 32'(4*i+1), 32'hA000_0000 + 32'(4*i)};
      model_beat(d, 1'(i), 2'd3, 1'b0);
      send_beat(d, 1'(i), 2'd3, 1'b0);
    end
    s_if.tvalid = 1'b0;
    drain();
    chk("t3_words",   64'(out_cyc.size()), 64'd32);
    chk("t3_accepts", 64'(acc_cyc.size()), 64'd8);
    if (out_cyc.size() == 32) chk("t3_span", 64'(out_cyc[31] - out_cyc[0]), 64'd31);
    if (acc_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) chk("t3_accept_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
    end

    // Single-word beats at one beat per cycle.
    acc_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      logic [127:0] d;
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_beat(d, 1'(i % 2), 2'd0, 1'(i / 3));
      send_beat(d, 1'(i % 2), 2'd0, 1'(i / 3));
    end
    s_if.tvalid = 1'b0;
    drain();
    chk("t4_words", 64'(out_cyc.size()), 64'd6);
    if (acc_cyc.size() == 6) begin
      for (int i = 1; i < 6; i++) chk("t4_accept_gap", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
    end

    // Reset after the second of four words has been taken.
    exp_q.push_back({1'b0, 32'h1111_1111});
    exp_q.push_back({1'b0, 32'h2222_2222});
    s_if.tdata  = BEAT_A;
    s_if.tlast  = 1'b1;
    cfg_words   = 2'd3;
    cfg_order   = 1'b0;
    s_if.tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("t5_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t5_busy",   64'(sts_busy),    64'd0);
    chk("t5_taken",  64'(exp_q.size()), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    model_beat(BEAT_B, 1'b1, 2'd3, 1'b0);
    send_beat(BEAT_B, 1'b1, 2'd3, 1'b0);
    s_if.tvalid = 1'b0;
    drain();

    // Random configuration under 50% output backpressure.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [127:0] d;
          logic         l;
          logic [1:0]   w;
          logic         o;
          d = {$urandom(), $urandom(), $urandom(), $urandom()};
          l = 1'($urandom_range(0, 1));
          w = 2'($urandom_range(0, 3));
          o = 1'($urandom_range(0, 1));
          model_beat(d, l, w, o);
          send_beat(d, l, w, o);
          if ($urandom_range(0, 3) == 0) begin
            s_if.tvalid = 1'b0;
            @(posedge aclk);
            #1;
          end
        end
        s_if.tvalid = 1'b0;
        rnd_done    = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge aclk);
          #1;
          m_if.tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_if.tready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
